// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end feeding a sequenced log shifter.
// One right-shift pass of 2**k bits per cycle; SLL runs on the bit-reversed operand.
module shift_arbiter #(
    parameter int DATA_W  = 64,
    parameter int SHAMT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [1:0]         req0_op,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic [1:0]         req1_op,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [DATA_W-1:0]  resp_result,
    output logic               resp_id,
    output logic               busy
);

    localparam int CNT_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(SHAMT_W - 1);

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   stage;
    logic               rr;

    logic signed [DATA_W-1:0] work_p1;
    logic [SHAMT_W-1:0]       shamt_p0;
    logic [1:0]               op_p0;
    logic                     id_p0;

    logic                     idle;
    logic                     gnt_id;
    logic                     accept;
    logic [DATA_W-1:0]        sel_a;
    logic [SHAMT_W-1:0]       sel_shamt;
    logic [1:0]               sel_op;
    logic signed [DATA_W-1:0] pass_out;
    logic signed [DATA_W-1:0] next_work;

    function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

    // Each stage is a fixed-distance shift; the stage index only steers a mux,
    // so no variable barrel shifter is built.
    function automatic logic signed [DATA_W-1:0] shift_pass(
        input logic signed [DATA_W-1:0] v,
        input logic [CNT_W-1:0]         k,
        input logic [1:0]               op
    );
        logic signed [DATA_W-1:0] r;
        r = v;
        for (int j = 0; j < SHAMT_W; j++) begin
            if (k == CNT_W'(j)) begin
                case (op)
                    OP_SRA:  r = v >>> (1 << j);
                    OP_ROR:  r = (v >> (1 << j)) | (v << (DATA_W - (1 << j)));
                    default: r = v >> (1 << j);
                endcase
            end
        end
        return r;
    endfunction

    always_comb begin
        idle = (state == IDLE) && !rst;
        if (req0_valid && req1_valid) begin
            gnt_id = ~rr;
        end else begin
            gnt_id = req1_valid;
        end
        accept     = idle && (req0_valid || req1_valid);
        req0_ready = accept && !gnt_id;
        req1_ready = accept && gnt_id;
        sel_a      = gnt_id ? req1_a     : req0_a;
        sel_shamt  = gnt_id ? req1_shamt : req0_shamt;
        sel_op     = gnt_id ? req1_op    : req0_op;
    end

    always_comb begin
        pass_out  = shift_pass(work_p1, stage, op_p0);
        next_work = shamt_p0[stage] ? pass_out : work_p1;
    end

    // Control: sequencer, arbitration pointer and response channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            stage       <= '0;
            rr          <= 1'b1;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_id     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= SHIFT;
                        stage <= '0;
                        rr    <= gnt_id;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (stage == LAST_STAGE) begin
                        state       <= DONE;
                        resp_valid  <= 1'b1;
                        resp_result <= (op_p0 == OP_SLL) ? bit_reverse(next_work) : next_work;
                        resp_id     <= id_p0;
                    end else begin
                        stage <= stage + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Data: operand capture at accept, one pass per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            work_p1  <= (sel_op == OP_SLL) ? bit_reverse(sel_a) : sel_a;
            shamt_p0 <= sel_shamt;
            op_p0    <= sel_op;
            id_p0    <= gnt_id;
        end else if (state == SHIFT) begin
            work_p1 <= next_work;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: ops, latency, arbitration, backpressure, reset.
module tb_shift_arbiter;

    localparam int DW = 64;
    localparam int SW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_a, req1_a;
    logic [SW-1:0] req0_shamt, req1_shamt;
    logic [1:0]    req0_op, req1_op;
    logic          resp_valid, resp_ready, resp_id, busy;
    logic [DW-1:0] resp_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.DATA_W(DW), .SHAMT_W(SW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_shamt(req0_shamt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_shamt(req1_shamt), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_id(resp_id), .busy(busy)
    );

    typedef struct packed {
        logic [63:0] a;
        logic [5:0]  sh;
        logic [1:0]  op;
        logic [63:0] exp;
    } vec_t;

    vec_t vtab [10];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction

    task automatic set_req(input int p, input logic v, input logic [63:0] a,
                           input logic [5:0] sh, input logic [1:0] op);
        if (p == 0) begin
            req0_valid = v; req0_a = a; req0_shamt = sh; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_shamt = sh; req1_op = op;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        resp_ready = 1'b0;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid",  64'(resp_valid),  64'd0);
        check("rst_result", resp_result,      64'd0);
        check("rst_id",     64'(resp_id),     64'd0);
        check("rst_busy",   64'(busy),        64'd0);
        check("rst_rdy",    64'({req1_ready, req0_ready}), 64'd0);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int p);
        int n;
        n = 0;
        #1;
        while (!rdy(p) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("grant", 64'(rdy(p)), 64'd1);
    endtask

    // Called just after the accept edge; returns edges until resp_valid is seen.
    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 3) check("rdy_busy", 64'({req1_ready, req0_ready}), 64'd0);
        end while (!resp_valid && lat < 20);
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("hs_valid", 64'(resp_valid), 64'd0);
        check("hs_busy",  64'(busy),       64'd0);
    endtask

    task automatic run_op(input string tag, input int p, input logic [63:0] a,
                          input logic [5:0] sh, input logic [1:0] op, input logic [63:0] exp);
        int lat;
        @(negedge clk);
        set_req(p, 1'b1, a, sh, op);
        wait_grant(p);
        @(posedge clk);
        #1;
        set_req(p, 1'b0, '0, '0, '0);
        wait_resp(lat);
        check({tag, "_lat"}, 64'(lat),     64'd6);
        check({tag, "_res"}, resp_result,  exp);
        check({tag, "_id"},  64'(resp_id), 64'(p));
        handshake();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        int lat;
        logic [63:0] res_hold;
        logic [63:0] fair_exp [2];

        vtab[0] = '{64'hF000_0000_0000_00F0, 6'd4,  2'b10, 64'hFF00_0000_0000_000F};
        vtab[1] = '{64'hF000_0000_0000_00F0, 6'd4,  2'b01, 64'h0000_0000_0000_0F00};
        vtab[2] = '{64'hF000_0000_0000_00F0, 6'd4,  2'b11, 64'h0F00_0000_0000_000F};
        vtab[3] = '{64'hF000_0000_0000_00F0, 6'd4,  2'b00, 64'h0F00_0000_0000_000F};
        vtab[4] = '{64'h8000_0000_0000_0000, 6'd63, 2'b00, 64'h0000_0000_0000_0001};
        vtab[5] = '{64'h8000_0000_0000_0000, 6'd63, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF};
        vtab[6] = '{64'h0000_0000_0000_0001, 6'd63, 2'b01, 64'h8000_0000_0000_0000};
        vtab[7] = '{64'h0123_4567_89AB_CDEF, 6'd32, 2'b11, 64'h89AB_CDEF_0123_4567};
        vtab[8] = '{64'h0123_4567_89AB_CDEF, 6'd36, 2'b11, 64'h789A_BCDE_F012_3456};
        vtab[9] = '{64'h0000_0000_0000_0001, 6'd42, 2'b01, 64'h0000_0400_0000_0000};

        do_reset();

        run_op("srl1", 0, 64'h8000_0000_0000_0001, 6'd1, 2'b00, 64'h4000_0000_0000_0000);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), 1, vtab[i].a, vtab[i].sh, vtab[i].op, vtab[i].exp);
        end

        run_op("zero_sra", 0, 64'h1234_5678_9ABC_DEF0, 6'd0, 2'b10, 64'h1234_5678_9ABC_DEF0);
        run_op("zero_sll", 0, 64'h1234_5678_9ABC_DEF0, 6'd0, 2'b01, 64'h1234_5678_9ABC_DEF0);

        // Backpressure with requester 1 waiting throughout.
        @(negedge clk);
        set_req(0, 1'b1, 64'h0000_0000_0000_00FF, 6'd4, 2'b01);
        wait_grant(0);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b1, 64'h5555_0000_0000_0000, 6'd1, 2'b00);
        wait_resp(lat);
        check("bp_lat", 64'(lat), 64'd6);
        res_hold = 64'h0000_0000_0000_0FF0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_res",   resp_result,     res_hold);
            check("bp_id",    64'(resp_id),    64'd0);
            check("bp_busy",  64'(busy),       64'd1);
            check("bp_rdy",   64'({req1_ready, req0_ready}), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("bp_rel_valid", 64'(resp_valid), 64'd0);
        check("bp_rel_busy",  64'(busy),       64'd0);
        check("bp_rel_rdy1",  64'(req1_ready), 64'd1);
        set_req(1, 1'b0, '0, '0, '0);

        // Fairness: both held valid for four transactions.
        do_reset();
        fair_exp[0] = 64'h0000_0000_0000_00FF;
        fair_exp[1] = 64'hFFFF_FFFF_0000_0000;
        @(negedge clk);
        set_req(0, 1'b1, 64'h0000_0000_0000_FF00, 6'd8,  2'b00);
        set_req(1, 1'b1, 64'hFFFF_0000_0000_0000, 6'd16, 2'b10);
        for (int t = 0; t < 4; t++) begin
            int n;
            n = 0;
            #1;
            while (!(req0_ready || req1_ready) && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("fair_onehot", 64'(req0_ready & req1_ready), 64'd0);
            check("fair_gnt",    64'(req1_ready), 64'(t % 2));
            @(posedge clk);
            wait_resp(lat);
            check("fair_lat", 64'(lat),     64'd6);
            check("fair_id",  64'(resp_id), 64'(t % 2));
            check("fair_res", resp_result,  fair_exp[t % 2]);
            handshake();
        end
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);

        // Reset during stage 3 of a requester-0 op, then a tie.
        @(negedge clk);
        set_req(0, 1'b1, 64'hFFFF_0000_FFFF_0000, 6'd5, 2'b00);
        wait_grant(0);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy",   64'(busy),       64'd0);
        check("mid_rst_valid",  64'(resp_valid), 64'd0);
        check("mid_rst_result", resp_result,     64'd0);
        check("mid_rst_id",     64'(resp_id),    64'd0);
        repeat (8) @(negedge clk);
        check("mid_no_resp", 64'(resp_valid), 64'd0);
        set_req(0, 1'b1, 64'h0000_0000_0000_00F0, 6'd4, 2'b00);
        set_req(1, 1'b1, 64'h0000_0000_0000_0F00, 6'd4, 2'b00);
        #1;
        check("tie_rdy", 64'({req1_ready, req0_ready}), 64'd1);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        wait_resp(lat);
        check("tie_id",  64'(resp_id),  64'd0);
        check("tie_res", resp_result,   64'h0000_0000_0000_000F);
        handshake();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
